layer_sched: RTL and testbench
==============================

LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- NUM_NODES, 10, neurons time-shared on one engine (2..16)
- NUM_IN, 10, activations per input vector
- NODE_LAT, 3, cycles from node_go to valid node_res (1..8)
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge
- reset, in, 1, asynchronous active-low reset
- in_valid, in, 1, input vector offered
- in_ready, out, 1, scheduler accepts a vector
- in_vec, in, NUM_IN*8, signed 8-bit activations, element 0 in the LSBs
- flush, in, 1, synchronous abort of the current frame
- act_vec, out, NUM_IN*8, latched activations driven to the engine
- node_sel, out, 4, weight/bias set index for the engine
- node_go, out, 1, engine issue strobe
- node_res, in, 8, engine output (saturated ReLU, 0..127)
- out_valid, out, 1, result vector available
- out_ready, in, 1, consumer takes the result
- out_vec, out, NUM_NODES*8, node results, node 0 in the LSBs
- busy, out, 1, high in any state other than IDLE
- sat_cnt, out, 5, count of saturated nodes (only when SAT_CNT_EN is defined)

Function
REQ-003 SHALL implement the FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-004 in_ready SHALL equal (state==IDLE); on an in_valid&&in_ready edge, act_vec SHALL latch in_vec and the state SHALL go to ISSUE.
REQ-005 act_vec SHALL hold stable from the accept edge until the next accept.
REQ-006 ISSUE SHALL assert node_go for exactly NUM_NODES consecutive cycles with node_sel = 0,1,...,NUM_NODES-1, then go to DRAIN.
REQ-007 node_sel SHALL hold its last value while node_go is low.
REQ-008 An issue delay line of depth NODE_LAT SHALL carry (go, sel); when its output go is high, node_res SHALL be written to out_vec slot sel in that cycle.
REQ-009 DRAIN SHALL go to DONE on the edge that captures node NUM_NODES-1.
REQ-010 out_valid SHALL be high only in DONE.
REQ-011 Latency from the accept edge to out_valid high SHALL be NUM_NODES+NODE_LAT+1 cycles (14 at defaults).
REQ-012 out_vec SHALL remain stable while out_valid is high.
REQ-013 DONE SHALL go to IDLE on out_valid&&out_ready; a new frame SHALL NOT be accepted in the same cycle (in_ready is low in DONE).
REQ-014 flush SHALL have priority over all transitions: next state IDLE, delay line cleared, no further captures, and out_valid low the following cycle.
REQ-015 out_vec SHALL keep the previous frame's contents after a flush.
REQ-016 flush in IDLE SHALL have no effect; in_valid in the same cycle as flush SHALL NOT be accepted.
REQ-017 in_valid in non-IDLE states SHALL be ignored, with no stall corruption.

Reset
REQ-018 Asserting reset SHALL immediately set the state to IDLE, the delay line to 0, and all of node_go, out_valid, busy, node_sel, act_vec, out_vec and sat_cnt to 0.
REQ-019 Asserting reset mid-frame SHALL discard the frame; the first accept after deassertion SHALL behave per REQ-011.

Configuration
REQ-020 With SAT_CNT_EN defined, sat_cnt SHALL clear on accept and increment on each capture where node_res==127.
REQ-021 sat_cnt SHALL hold its value while in DONE.
REQ-022 Without SAT_CNT_EN, the sat_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-023 Shared package ecg_nn_pkg SHALL hold:
- the state enum
- the DW=8 constant
- the saturation constant SAT_MAX=127
- default NUM_NODES/NODE_LAT
REQ-024 The delay line SHALL be a sub-module lat_pipe, parameterised by depth and sel width, with asynchronous active-low reset and a synchronous clear.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Defaults; accept at cycle 0 with a model engine returning 10+sel -> node_go in cycles 1..10, out_valid at cycle 14, out_vec bytes = 10..19.
- out_ready held low 5 cycles -> out_valid and out_vec stable, in_ready low; single handshake -> IDLE, in_ready high the next cycle.
- flush asserted in cycle 6 of ISSUE -> IDLE next cycle, no out_valid, node_go low; the next frame completes in 14 cycles.
- SAT_CNT_EN defined, engine returns 127 for sel 2,5,9 -> sat_cnt=3 in DONE; without the macro, the build has no sat_cnt port.
- reset pulsed during DRAIN -> all outputs 0 immediately; in_valid held high -> accepted on the first edge after release.
- NODE_LAT=1, NUM_NODES=2 -> out_valid 4 cycles after accept.

Source files
------------

// File: rtl/ecg_nn_pkg.sv
// Shared types and constants for the time-shared neuron layer scheduler.
package ecg_nn_pkg;
  localparam int DW            = 8;
  localparam int SEL_W         = 4;
  localparam logic [DW-1:0] SAT_MAX = 8'd127;
  localparam int NUM_NODES_DEF = 10;
  localparam int NODE_LAT_DEF  = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/lat_pipe.sv
// Issue delay line: carries (go, sel) from the engine issue point to the
// cycle its result appears on node_res. Synchronous clear empties it.
module lat_pipe #(
  parameter int DEPTH = 3,
  parameter int SW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          go_in,
  input  logic [SW-1:0] sel_in,
  output logic          go_out,
  output logic [SW-1:0] sel_out
);
  logic [DEPTH:1]         vld_pipe;
  logic [DEPTH:1][SW-1:0] sel_pipe;

  // Shift register; stage 1 takes the issue, stage DEPTH is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sel_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
      sel_pipe <= '0;
    end else begin
      vld_pipe[1] <= go_in;
      sel_pipe[1] <= sel_in;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sel_pipe[i] <= sel_pipe[i-1];
      end
    end
  end

  assign go_out  = vld_pipe[DEPTH];
  assign sel_out = sel_pipe[DEPTH];
endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: latches one input vector, issues NUM_NODES neurons
// back-to-back to a shared engine, gathers results into out_vec.
// Optional saturation counter enabled by defining SAT_CNT_EN.
module layer_sched
  import ecg_nn_pkg::*;
#(
  parameter int NUM_NODES = NUM_NODES_DEF,
  parameter int NUM_IN    = 10,
  parameter int NODE_LAT  = NODE_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*DW-1:0]    in_vec,
  input  logic                    flush,
  output logic [NUM_IN*DW-1:0]    act_vec,
  output logic [SEL_W-1:0]        node_sel,
  output logic                    node_go,
  input  logic [DW-1:0]           node_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_NODES*DW-1:0] out_vec,
  output logic                    busy
`ifdef SAT_CNT_EN
  ,
  output logic [4:0]              sat_cnt
`endif
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_NODES - 1);

  state_t                       state, state_n;
  logic [SEL_W-1:0]             sel_q, p_sel;
  logic                         p_go, accept, cap;
  logic [NUM_NODES-1:0][DW-1:0] res_q;

  assign in_ready  = (state == IDLE);
  assign node_go   = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign node_sel  = sel_q;
  assign out_vec   = res_q;
  // flush wins over an accept and suppresses any capture in its cycle
  assign accept    = in_ready && in_valid && !flush;
  assign cap       = p_go && !flush;

  lat_pipe #(.DEPTH(NODE_LAT), .SW(SEL_W)) u_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (flush),
    .go_in   (node_go),
    .sel_in  (sel_q),
    .go_out  (p_go),
    .sel_out (p_sel)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (accept) state_n = ISSUE;
      ISSUE: if (sel_q == LAST) state_n = DRAIN;
      DRAIN: if (cap && p_sel == LAST) state_n = DONE;
      DONE:  if (out_ready) state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Activation latch: loads only on accept so the engine sees a stable vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      act_vec <= '0;
    else if (accept) act_vec <= in_vec;
  end

  // Node index: restarts on accept, steps through ISSUE, parks on the last node.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          sel_q <= '0;
    else if (accept)                                     sel_q <= '0;
    else if (state == ISSUE && !flush && sel_q != LAST)  sel_q <= sel_q + 1'b1;
  end

  // Result gather: the delayed select steers node_res into its slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) res_q <= '0;
    else if (cap) begin
      for (int n = 0; n < NUM_NODES; n++)
        if (p_sel == SEL_W'(n)) res_q[n] <= node_res;
    end
  end

`ifdef SAT_CNT_EN
  // Saturation counter: counts captured results pinned at SAT_MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          sat_cnt <= '0;
    else if (accept)                     sat_cnt <= '0;
    else if (cap && node_res == SAT_MAX) sat_cnt <= sat_cnt + 5'd1;
  end
`endif
endmodule

// File: tb/tb_layer_sched.sv
// Bench for layer_sched: model engine returns tab[sel] NODE_LAT cycles
// after issue; expected results come from the table and the latency rule.
module tb_layer_sched;
  localparam int N = 10, L = 3, N2 = 2, L2 = 1;

  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 0, flush = 0, out_ready = 0;
  logic [79:0] in_vec = '0;
  logic        in_ready, node_go, out_valid, busy;
  logic [79:0] act_vec, out_vec;
  logic [3:0]  node_sel;
  logic [7:0]  node_res;
  logic        in_valid2 = 0, out_ready2 = 0;
  logic [79:0] in_vec2 = '0, act_vec2;
  logic        in_ready2, node_go2, out_valid2, busy2;
  logic [15:0] out_vec2;
  logic [3:0]  node_sel2;
  logic [7:0]  node_res2;
`ifdef SAT_CNT_EN
  logic [4:0]  sat_cnt, sat_cnt2;
`endif

  logic [7:0] tab [16];
  logic [7:0] tab2[16];
  logic [3:0] hist[9];
  logic [3:0] hist2[2];
  int chk_cnt = 0, pass_cnt = 0;

  always #5 clk = ~clk;

  layer_sched #(.NUM_NODES(N), .NUM_IN(10), .NODE_LAT(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .flush(flush), .act_vec(act_vec), .node_sel(node_sel),
    .node_go(node_go), .node_res(node_res), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .busy(busy)
`ifdef SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  layer_sched #(.NUM_NODES(N2), .NUM_IN(10), .NODE_LAT(L2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_vec(in_vec2), .flush(1'b0), .act_vec(act_vec2), .node_sel(node_sel2),
    .node_go(node_go2), .node_res(node_res2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_vec(out_vec2), .busy(busy2)
`ifdef SAT_CNT_EN
    , .sat_cnt(sat_cnt2)
`endif
  );

  // Model engines: remember the select offered each cycle, answer L cycles later.
  always @(negedge clk) begin
    for (int j = 8; j > 0; j--) hist[j] = hist[j-1];
    hist[0]  = node_sel;
    node_res = tab[hist[L]];
    hist2[1]  = hist2[0];
    hist2[0]  = node_sel2;
    node_res2 = tab2[hist2[L2]];
  end

  function automatic logic [79:0] rvec();
    return 80'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [79:0] exp_vec();
    logic [79:0] r;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = tab[i];
    return r;
  endfunction

  function automatic int exp_sat();
    int c = 0;
    for (int i = 0; i < N; i++) if (tab[i] == 8'd127) c++;
    return c;
  endfunction

  // One frame from accept to out_valid; called right after a negedge.
  task automatic run_frame(input logic [79:0] v, input bit noisy);
    int lat, go_n;
    bit go_ok;
    in_vec = v; in_valid = 1;
    lat = 0; go_n = 0; go_ok = 1;
    do begin
      @(negedge clk); lat++;
      if (noisy) begin in_valid = 1'($urandom_range(0, 1)); in_vec = rvec(); end
      else in_valid = 0;
      if (node_go) begin
        if (node_sel !== 4'(go_n) || lat != go_n + 1) go_ok = 0;
        go_n++;
      end
    end while (!out_valid && lat < 60);
    in_valid = 0;
    chk_cnt++;
    if (lat !== N + L + 1) $display("FAIL latency: got %0d want %0d", lat, N + L + 1);
    else pass_cnt++;
    chk_cnt++;
    if (go_n !== N || !go_ok) $display("FAIL go_seq: got %0d ok=%0d want %0d ok=1", go_n, go_ok, N);
    else pass_cnt++;
    chk_cnt++;
    if (act_vec !== v) $display("FAIL act_vec: got %h want %h", act_vec, v);
    else pass_cnt++;
    chk_cnt++;
    if (out_vec !== exp_vec()) $display("FAIL out_vec: got %h want %h", out_vec, exp_vec());
    else pass_cnt++;
`ifdef SAT_CNT_EN
    chk_cnt++;
    if (sat_cnt !== 5'(exp_sat())) $display("FAIL sat_cnt: got %0d want %0d", sat_cnt, exp_sat());
    else pass_cnt++;
`endif
  endtask

  task automatic drain_out(input int wait_n);
    repeat (wait_n) @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk_cnt++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL handshake: got %b want 01", {out_valid, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({busy, out_valid, node_go, in_ready} !== 4'b0001) $display("FAIL rst_ctl: got %b want 0001", {busy, out_valid, node_go, in_ready});
    else pass_cnt++;
    chk_cnt++;
    if (node_sel !== 4'd0) $display("FAIL rst_sel: got %0d want 0", node_sel);
    else pass_cnt++;
    chk_cnt++;
    if (act_vec !== '0 || out_vec !== '0) $display("FAIL rst_data: got %h %h want 0", act_vec, out_vec);
    else pass_cnt++;
    reset = 1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) tab[i] = 8'(10 + i);
    @(negedge clk);
    run_frame(rvec(), 0);
  endtask

  task automatic test_backpressure();
    logic [79:0] e;
    e = exp_vec();
    repeat (5) begin
      @(negedge clk);
      chk_cnt++;
      if ({out_valid, in_ready} !== 2'b10 || out_vec !== e) $display("FAIL hold: got %b %h want 10 %h", {out_valid, in_ready}, out_vec, e);
      else pass_cnt++;
    end
    out_ready = 1; in_valid = 1; in_vec = rvec();
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    chk_cnt++;
    if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL release: got %b want 010", {out_valid, in_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [79:0] e;
    bit seen;
    e = exp_vec();
    // nodes 0..2 arrive before/at the flush; keep them identical so out_vec is unambiguous
    for (int i = 3; i < N; i++) tab[i] = tab[i] ^ 8'h01;
    in_vec = rvec(); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if ({node_go, node_sel} !== 5'h15) $display("FAIL issue6: got %h want 15", {node_go, node_sel});
    else pass_cnt++;
    flush = 1; in_valid = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk_cnt++;
    if ({busy, node_go, out_valid, in_ready} !== 4'b0001) $display("FAIL flush_idle: got %b want 0001", {busy, node_go, out_valid, in_ready});
    else pass_cnt++;
    seen = 0;
    repeat (10) begin @(negedge clk); if (out_valid || busy) seen = 1; end
    chk_cnt++;
    if (seen !== 1'b0 || out_vec !== e) $display("FAIL flush_keep: got %0d %h want 0 %h", seen, out_vec, e);
    else pass_cnt++;
    flush = 1; in_valid = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk_cnt++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL flush_accept: got %b want 01", {busy, in_ready});
    else pass_cnt++;
    for (int i = 0; i < 16; i++) tab[i] = 8'($urandom_range(0, 127));
    run_frame(rvec(), 1);
    drain_out(1);
  endtask

  task automatic test_sat();
    for (int i = 0; i < 16; i++) tab[i] = 8'($urandom_range(0, 126));
    tab[2] = 8'd127; tab[5] = 8'd127; tab[9] = 8'd127;
    run_frame(rvec(), 0);
`ifdef SAT_CNT_EN
    repeat (3) begin
      @(negedge clk);
      chk_cnt++;
      if (sat_cnt !== 5'd3) $display("FAIL sat_hold: got %0d want 3", sat_cnt);
      else pass_cnt++;
    end
`endif
    drain_out(0);
  endtask

  task automatic test_back_to_back();
    repeat (6) begin
      for (int i = 0; i < 16; i++)
        tab[i] = ($urandom_range(0, 7) == 0) ? 8'd127 : 8'($urandom_range(0, 127));
      run_frame(rvec(), 1);
      drain_out($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) tab[i] = 8'($urandom_range(0, 127));
    in_vec = rvec(); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (11) @(negedge clk);
    chk_cnt++;
    if ({busy, node_go, out_valid} !== 3'b100) $display("FAIL drain: got %b want 100", {busy, node_go, out_valid});
    else pass_cnt++;
    reset = 0; in_valid = 1; in_vec = rvec();
    #1;
    chk_cnt++;
    if ({busy, out_valid, node_go, in_ready} !== 4'b0001 || node_sel !== 4'd0) $display("FAIL async_rst: got %b %0d want 0001 0", {busy, out_valid, node_go, in_ready}, node_sel);
    else pass_cnt++;
    chk_cnt++;
    if (act_vec !== '0 || out_vec !== '0) $display("FAIL async_rst_data: got %h %h want 0", act_vec, out_vec);
    else pass_cnt++;
`ifdef SAT_CNT_EN
    chk_cnt++;
    if (sat_cnt !== 5'd0) $display("FAIL async_rst_sat: got %0d want 0", sat_cnt);
    else pass_cnt++;
`endif
    @(negedge clk);
    reset = 1;
    run_frame(rvec(), 0);
    drain_out(0);
  endtask

  task automatic test_small();
    int lat;
    logic [79:0] v;
    tab2[0] = 8'($urandom_range(0, 127));
    tab2[1] = 8'($urandom_range(0, 127));
    v = rvec();
    in_vec2 = v; in_valid2 = 1; lat = 0;
    do begin @(negedge clk); lat++; in_valid2 = 0; end
    while (!out_valid2 && lat < 20);
    chk_cnt++;
    if (lat !== N2 + L2 + 1) $display("FAIL small_lat: got %0d want %0d", lat, N2 + L2 + 1);
    else pass_cnt++;
    chk_cnt++;
    if (out_vec2 !== {tab2[1], tab2[0]} || act_vec2 !== v) $display("FAIL small_vec: got %h want %h", out_vec2, {tab2[1], tab2[0]});
    else pass_cnt++;
    out_ready2 = 1;
    @(negedge clk);
    out_ready2 = 0;
    chk_cnt++;
    if ({out_valid2, in_ready2} !== 2'b01) $display("FAIL small_hs: got %b want 01", {out_valid2, in_ready2});
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin tab[i] = 0; tab2[i] = 0; end
    for (int j = 0; j < 9; j++) hist[j] = 0;
    hist2[0] = 0; hist2[1] = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_sat();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
